vx_dvg_arb: RTL and testbench

Arbitration and sequencing controller in front of the per-core split/join (IPDOM) unit. It accepts split/join requests from `NUM_REQS` execute-side requesters, grants one per cycle round-robin, and forwards it through a register stage to the split/join unit. It keeps a per-warp divergence-depth counter so that stack overflow and underflow are caught before they reach the IPDOM stacks. It also blocks a warp from issuing another split/join while its join result is still in flight.

---
 rtl/vx_dvg_arb_pkg.sv | 26 ++
 rtl/vx_dvg_arb_rr.sv | 42 ++++
 rtl/vx_dvg_arb.sv | 178 +++++++++++++++++
 tb/tb_vx_dvg_arb.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_dvg_arb_pkg.sv
// Shared types and sizing for the divergence arbiter in front of the IPDOM split/join unit.
package vx_dvg_arb_pkg;

  localparam int NUM_THREADS = 4;
  localparam int NUM_WARPS   = 4;
  localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  // IPDOM stack capacity per warp is one less than the thread count, never below 1.
  localparam int DVG_DEPTH_MAX = (NUM_THREADS > 1) ? NUM_THREADS - 1 : 1;
  localparam int DVG_DEPTHW    = $clog2(DVG_DEPTH_MAX + 1);

  typedef struct packed {
    logic                   valid;
    logic                   is_dvg;
    logic [NUM_THREADS-1:0] then_tmask;
    logic [NUM_THREADS-1:0] else_tmask;
    logic [31:0]            next_pc;
  } split_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_dvg;
    logic [DVG_DEPTHW-1:0] stack_ptr;
  } join_t;

endpackage

// File: rtl/vx_dvg_arb_rr.sv
// Lock-free round-robin arbiter with a one-hot grant; the priority pointer
// moves past the winner and holds when nothing is granted.
module vx_dvg_arb_rr #(
  parameter int NUM_REQS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  output logic [NUM_REQS-1:0] grant,
  output logic                grant_valid
);

  localparam int PTRW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [PTRW-1:0] ptr_q;
  logic [PTRW-1:0] ptr_next;

  // Scan requesters starting at the pointer and take the first one asserted.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_valid = 1'b0;
    ptr_next    = ptr_q;
    for (int i = 0; i < NUM_REQS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      if (!grant_valid && requests[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
        ptr_next    = (idx == NUM_REQS - 1) ? '0 : PTRW'(idx + 1);
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_next;
  end

endmodule

// File: rtl/vx_dvg_arb.sv
// Split/join arbitration in front of the IPDOM unit: round-robin grant,
// per-warp divergence depth tracking with overflow/underflow screening,
// and a per-warp join-pending lock until the join result returns.
module vx_dvg_arb
  import vx_dvg_arb_pkg::*;
#(
  parameter int NUM_REQS   = 2,
  parameter int THREAD_CNT = NUM_THREADS,
  parameter int DEPTH_MAX  = (THREAD_CNT > 1) ? THREAD_CNT - 1 : 1,
  parameter int DEPTHW     = $clog2(DEPTH_MAX + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQS-1:0]                   req_valid,
  input  logic [NUM_REQS-1:0][NW_WIDTH-1:0]     req_wid,
  input  split_t [NUM_REQS-1:0]                 req_split,
  input  join_t  [NUM_REQS-1:0]                 req_sjoin,
  output logic [NUM_REQS-1:0]                   req_ready,
  output logic                                  sj_valid,
  output logic [NW_WIDTH-1:0]                   sj_wid,
  output split_t                                sj_split,
  output join_t                                 sj_sjoin,
  input  logic                                  join_valid,
  input  logic [NW_WIDTH-1:0]                   join_wid,
  output logic [NUM_WARPS-1:0]                  warp_busy,
  output logic [NUM_WARPS-1:0][DEPTHW-1:0]      dvg_depth,
  output logic                                  err_overflow,
  output logic                                  err_underflow,
  output logic                                  err_proto
);

  localparam logic [DEPTHW-1:0] DEPTH_MAX_W = DEPTHW'(DEPTH_MAX);

  logic [NUM_WARPS-1:0] pending;
  logic [NUM_REQS-1:0]  eligible;
  logic                 any_grant;

  logic [NW_WIDTH-1:0]  g_wid;
  split_t               g_split;
  join_t                g_sjoin;
  split_t               fwd_split;
  join_t                fwd_sjoin;
  logic [DEPTHW-1:0]    cur_depth;
  logic                 join_taken;
  logic                 do_push;
  logic                 do_pop;
  logic                 set_ovf;
  logic                 set_unf;
  logic                 set_proto;

  assign warp_busy = pending;

  // A warp with a join in flight cannot issue; there is no same-cycle bypass.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = req_valid[i] && !pending[req_wid[i]];
    end
  end

  vx_dvg_arb_rr #(
    .NUM_REQS (NUM_REQS)
  ) u_rr (
    .clk         (clk),
    .reset       (reset),
    .requests    (eligible),
    .grant       (req_ready),
    .grant_valid (any_grant)
  );

  // Select the granted request (grant is one-hot).
  always_comb begin
    g_wid   = '0;
    g_split = '0;
    g_sjoin = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (req_ready[i]) begin
        g_wid   = req_wid[i];
        g_split = req_split[i];
        g_sjoin = req_sjoin[i];
      end
    end
  end

  // Screen the granted request against the warp's stack depth and patch the payload.
  always_comb begin
    cur_depth  = dvg_depth[g_wid];
    fwd_split  = g_split;
    fwd_sjoin  = g_sjoin;
    join_taken = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    set_proto  = 1'b0;
    if (any_grant) begin
      // A request carrying both a split and a join keeps the split only; the
      // dropped join never reaches the IPDOM unit, so no return will follow.
      if (g_split.valid && g_sjoin.valid) begin
        set_proto       = 1'b1;
        fwd_sjoin.valid = 1'b0;
      end
      join_taken = g_sjoin.valid && !g_split.valid;
      if (g_split.valid && g_split.is_dvg) begin
        if (cur_depth == DEPTH_MAX_W) begin
          fwd_split.is_dvg = 1'b0;
          set_ovf          = 1'b1;
        end else begin
          do_push = 1'b1;
        end
      end
      if (join_taken && g_sjoin.is_dvg) begin
        if (cur_depth == '0) begin
          fwd_sjoin.is_dvg = 1'b0;
          set_unf          = 1'b1;
        end else begin
          do_pop = 1'b1;
        end
      end
    end
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic [DEPTHW-1:0] depth_q;
    logic              pending_q;
    logic              hit;

    assign hit          = any_grant && (g_wid == NW_WIDTH'(w));
    assign dvg_depth[w] = depth_q;
    assign pending[w]   = pending_q;

    // Depth follows accepted pushes/pops; pending is held from join grant to join return.
    always_ff @(posedge clk) begin
      if (reset) begin
        depth_q   <= '0;
        pending_q <= 1'b0;
      end else begin
        if (hit && do_push)     depth_q <= depth_q + DEPTHW'(1);
        else if (hit && do_pop) depth_q <= depth_q - DEPTHW'(1);
        if (hit && join_taken)
          pending_q <= 1'b1;
        else if (join_valid && (join_wid == NW_WIDTH'(w)))
          pending_q <= 1'b0;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_proto     <= 1'b0;
    end else begin
      err_overflow  <= err_overflow  | set_ovf;
      err_underflow <= err_underflow | set_unf;
      err_proto     <= err_proto     | set_proto;
    end
  end

  // Output register stage; payload holds its last value when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sj_valid <= 1'b0;
      sj_wid   <= '0;
      sj_split <= '0;
      sj_sjoin <= '0;
    end else begin
      sj_valid <= any_grant;
      if (any_grant) begin
        sj_wid   <= g_wid;
        sj_split <= fwd_split;
        sj_sjoin <= fwd_sjoin;
      end
    end
  end

endmodule

// File: tb/tb_vx_dvg_arb.sv
// Bench for vx_dvg_arb: scenario tasks drive requests and queue the expected
// forwarded transaction; a monitor pops and compares when sj_valid appears.
module tb_vx_dvg_arb;
  import vx_dvg_arb_pkg::*;

  localparam int NR = 2;
  localparam int DW = DVG_DEPTHW;

  logic                              clk = 1'b0;
  logic                              reset;
  logic [NR-1:0]                     req_valid;
  logic [NR-1:0][NW_WIDTH-1:0]       req_wid;
  split_t [NR-1:0]                   req_split;
  join_t  [NR-1:0]                   req_sjoin;
  logic [NR-1:0]                     req_ready;
  logic                              sj_valid;
  logic [NW_WIDTH-1:0]               sj_wid;
  split_t                            sj_split;
  join_t                             sj_sjoin;
  logic                              join_valid;
  logic [NW_WIDTH-1:0]               join_wid;
  logic [NUM_WARPS-1:0]              warp_busy;
  logic [NUM_WARPS-1:0][DW-1:0]      dvg_depth;
  logic                              err_overflow;
  logic                              err_underflow;
  logic                              err_proto;

  typedef struct {
    logic [NW_WIDTH-1:0] wid;
    split_t              s;
    join_t               j;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vx_dvg_arb dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_wid       (req_wid),
    .req_split     (req_split),
    .req_sjoin     (req_sjoin),
    .req_ready     (req_ready),
    .sj_valid      (sj_valid),
    .sj_wid        (sj_wid),
    .sj_split      (sj_split),
    .sj_sjoin      (sj_sjoin),
    .join_valid    (join_valid),
    .join_wid      (join_wid),
    .warp_busy     (warp_busy),
    .dvg_depth     (dvg_depth),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_proto     (err_proto)
  );

  function automatic split_t mk_split(input logic v, input logic d, input logic [31:0] pc);
    split_t s;
    s.valid      = v;
    s.is_dvg     = d;
    s.then_tmask = pc[NUM_THREADS-1:0];
    s.else_tmask = ~pc[NUM_THREADS-1:0];
    s.next_pc    = pc;
    return s;
  endfunction

  function automatic join_t mk_join(input logic v, input logic d, input logic [DW-1:0] sp);
    join_t j;
    j.valid     = v;
    j.is_dvg    = d;
    j.stack_ptr = sp;
    return j;
  endfunction

  task automatic push_exp(input logic [NW_WIDTH-1:0] wid, input split_t s, input join_t j);
    exp_t e;
    e.wid = wid;
    e.s   = s;
    e.j   = j;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    req_valid  = '0;
    req_wid    = '0;
    req_split  = '0;
    req_sjoin  = '0;
    join_valid = 1'b0;
    join_wid   = '0;
  endtask

  // Scoreboard monitor: every forwarded transaction must match the oldest expectation.
  always @(negedge clk) begin
    if (sj_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sj_unexpected got wid=%0d split=%h join=%h", sj_wid, sj_split, sj_sjoin);
      end else begin
        mon_e = sb.pop_front();
        if (sj_wid !== mon_e.wid || sj_split !== mon_e.s || sj_sjoin !== mon_e.j) begin
          errors++;
          $display("FAIL sj_payload got wid=%0d split=%h join=%h exp wid=%0d split=%h join=%h",
                   sj_wid, sj_split, sj_sjoin, mon_e.wid, mon_e.s, mon_e.j);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b exp 00", req_ready);
    end
    checks++;
    if ({sj_valid, sj_wid, sj_split, sj_sjoin} !== '0) begin
      errors++; $display("FAIL reset_sj got v=%b wid=%0d split=%h join=%h exp all 0", sj_valid, sj_wid, sj_split, sj_sjoin);
    end
    checks++;
    if (warp_busy !== '0 || dvg_depth !== '0) begin
      errors++; $display("FAIL reset_state got busy=%b depth=%h exp 0", warp_busy, dvg_depth);
    end
    checks++;
    if ({err_overflow, err_underflow, err_proto} !== 3'b000) begin
      errors++; $display("FAIL reset_err got %b exp 000", {err_overflow, err_underflow, err_proto});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rr();
    logic [NR-1:0] exp_ready;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle_inputs();
      req_valid    = 2'b11;
      req_wid[0]   = NW_WIDTH'((c < 2) ? 0 : 2);
      req_wid[1]   = NW_WIDTH'((c < 2) ? 1 : 3);
      req_split[0] = mk_split(1'b1, 1'b0, 32'(32'h100 + c * 8));
      req_split[1] = mk_split(1'b1, 1'b0, 32'(32'h104 + c * 8));
      #1;
      exp_ready = (c % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL rr_grant c=%0d got %b exp %b", c, req_ready, exp_ready);
      end
      if (c % 2 == 0) push_exp(req_wid[0], req_split[0], '0);
      else            push_exp(req_wid[1], req_split[1], '0);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #1;
    checks++;
    if (sj_valid !== 1'b0 || sj_wid !== NW_WIDTH'(3)) begin
      errors++; $display("FAIL rr_idle_hold got v=%b wid=%0d exp v=0 wid=3", sj_valid, sj_wid);
    end
    checks++;
    if (dvg_depth !== '0) begin
      errors++; $display("FAIL rr_depth got %h exp 0", dvg_depth);
    end
  endtask

  task automatic test_rr_hold();
    logic [NR-1:0] vals [5];
    logic [NR-1:0] exps [5];
    vals = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b11};
    exps = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      idle_inputs();
      req_valid    = vals[c];
      req_wid[0]   = NW_WIDTH'(0);
      req_wid[1]   = NW_WIDTH'(1);
      req_split[0] = mk_split(1'b1, 1'b0, 32'(32'h180 + c * 8));
      req_split[1] = mk_split(1'b1, 1'b0, 32'(32'h184 + c * 8));
      #1;
      checks++;
      if (req_ready !== exps[c]) begin
        errors++; $display("FAIL rr_hold c=%0d got %b exp %b", c, req_ready, exps[c]);
      end
      if (exps[c] == 2'b01) push_exp(req_wid[0], req_split[0], '0);
      if (exps[c] == 2'b10) push_exp(req_wid[1], req_split[1], '0);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_join_pending();
    @(negedge clk);
    idle_inputs();
    req_valid[0] = 1'b1;
    req_wid[0]   = NW_WIDTH'(2);
    req_split[0] = mk_split(1'b1, 1'b1, 32'h200);
    #1;
    push_exp(NW_WIDTH'(2), req_split[0], '0);
    @(negedge clk);
    req_split[0] = '0;
    req_sjoin[0] = mk_join(1'b1, 1'b1, DW'(1));
    #1;
    checks++;
    if (req_ready !== 2'b01 || dvg_depth[2] !== DW'(1)) begin
      errors++; $display("FAIL jp_join_grant got ready=%b depth=%0d exp ready=01 depth=1", req_ready, dvg_depth[2]);
    end
    push_exp(NW_WIDTH'(2), '0, req_sjoin[0]);
    @(negedge clk);
    idle_inputs();
    req_valid[1] = 1'b1;
    req_wid[1]   = NW_WIDTH'(2);
    req_split[1] = mk_split(1'b1, 1'b0, 32'h300);
    #1;
    checks++;
    if (req_ready !== 2'b00 || warp_busy[2] !== 1'b1 || dvg_depth[2] !== '0) begin
      errors++; $display("FAIL jp_blocked1 got ready=%b busy=%b depth=%0d exp ready=00 busy=1 depth=0", req_ready, warp_busy[2], dvg_depth[2]);
    end
    @(negedge clk);
    join_valid = 1'b1;
    join_wid   = NW_WIDTH'(2);
    #1;
    checks++;
    if (req_ready !== 2'b00 || warp_busy[2] !== 1'b1) begin
      errors++; $display("FAIL jp_blocked2 got ready=%b busy=%b exp ready=00 busy=1", req_ready, warp_busy[2]);
    end
    @(negedge clk);
    join_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b10 || warp_busy[2] !== 1'b0) begin
      errors++; $display("FAIL jp_release got ready=%b busy=%b exp ready=10 busy=0", req_ready, warp_busy[2]);
    end
    push_exp(NW_WIDTH'(2), req_split[1], '0);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle_inputs();
      req_valid[0] = 1'b1;
      req_wid[0]   = NW_WIDTH'(0);
      req_split[0] = mk_split(1'b1, 1'b1, 32'(32'h400 + k * 4));
      #1;
      checks++;
      if (req_ready !== 2'b01 || dvg_depth[0] !== DW'((k < 3) ? k : 3) || err_overflow !== 1'b0) begin
        errors++; $display("FAIL ovf_step k=%0d got ready=%b depth=%0d err=%b exp ready=01 depth=%0d err=0",
                           k, req_ready, dvg_depth[0], err_overflow, (k < 3) ? k : 3);
      end
      push_exp(NW_WIDTH'(0), mk_split(1'b1, (k < 3), 32'(32'h400 + k * 4)), '0);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (dvg_depth[0] !== DW'(3) || err_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_final got depth=%0d err=%b exp depth=3 err=1", dvg_depth[0], err_overflow);
    end
  endtask

  task automatic test_underflow();
    @(negedge clk);
    idle_inputs();
    req_valid[1] = 1'b1;
    req_wid[1]   = NW_WIDTH'(1);
    req_sjoin[1] = mk_join(1'b1, 1'b1, DW'(0));
    #1;
    checks++;
    if (req_ready !== 2'b10 || err_underflow !== 1'b0) begin
      errors++; $display("FAIL unf_grant got ready=%b err=%b exp ready=10 err=0", req_ready, err_underflow);
    end
    push_exp(NW_WIDTH'(1), '0, mk_join(1'b1, 1'b0, DW'(0)));
    @(negedge clk);
    idle_inputs();
    join_valid = 1'b1;
    join_wid   = NW_WIDTH'(1);
    #1;
    checks++;
    if (err_underflow !== 1'b1 || warp_busy[1] !== 1'b1 || dvg_depth[1] !== '0) begin
      errors++; $display("FAIL unf_state got err=%b busy=%b depth=%0d exp err=1 busy=1 depth=0", err_underflow, warp_busy[1], dvg_depth[1]);
    end
    // A return for warp 0, which has nothing pending, must be ignored.
    @(negedge clk);
    join_wid = NW_WIDTH'(0);
    @(negedge clk);
    join_valid = 1'b0;
    #1;
    checks++;
    if (warp_busy !== '0 || dvg_depth[0] !== DW'(3) || err_proto !== 1'b0) begin
      errors++; $display("FAIL stray_join got busy=%b depth0=%0d proto=%b exp busy=0 depth0=3 proto=0", warp_busy, dvg_depth[0], err_proto);
    end
  endtask

  task automatic test_proto();
    @(negedge clk);
    idle_inputs();
    req_valid[0] = 1'b1;
    req_wid[0]   = NW_WIDTH'(3);
    req_split[0] = mk_split(1'b1, 1'b1, 32'h500);
    req_sjoin[0] = mk_join(1'b1, 1'b1, DW'(1));
    #1;
    checks++;
    if (req_ready !== 2'b01 || err_proto !== 1'b0) begin
      errors++; $display("FAIL proto_grant got ready=%b err=%b exp ready=01 err=0", req_ready, err_proto);
    end
    push_exp(NW_WIDTH'(3), mk_split(1'b1, 1'b1, 32'h500), mk_join(1'b0, 1'b1, DW'(1)));
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (err_proto !== 1'b1 || dvg_depth[3] !== DW'(1)) begin
      errors++; $display("FAIL proto_state got err=%b depth3=%0d exp err=1 depth3=1", err_proto, dvg_depth[3]);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    idle_inputs();
    req_valid[0] = 1'b1;
    req_wid[0]   = NW_WIDTH'(2);
    req_sjoin[0] = mk_join(1'b1, 1'b0, DW'(0));
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rst_join_grant got %b exp 01", req_ready);
    end
    push_exp(NW_WIDTH'(2), '0, req_sjoin[0]);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if (warp_busy[2] !== 1'b1) begin
      errors++; $display("FAIL rst_pre_busy got %b exp 1", warp_busy[2]);
    end
    @(negedge clk);
    reset      = 1'b0;
    join_valid = 1'b1;
    join_wid   = NW_WIDTH'(2);
    #1;
    checks++;
    if ({sj_valid, sj_wid, sj_split, sj_sjoin} !== '0 || warp_busy !== '0 || dvg_depth !== '0 ||
        {err_overflow, err_underflow, err_proto} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_outputs got v=%b wid=%0d busy=%b depth=%h err=%b exp all 0",
                         sj_valid, sj_wid, warp_busy, dvg_depth, {err_overflow, err_underflow, err_proto});
    end
    @(negedge clk);
    idle_inputs();
    req_valid[0] = 1'b1;
    req_wid[0]   = NW_WIDTH'(2);
    req_split[0] = mk_split(1'b1, 1'b0, 32'h600);
    #1;
    checks++;
    if (req_ready !== 2'b01 || warp_busy !== '0 || dvg_depth !== '0) begin
      errors++; $display("FAIL rst_late_join got ready=%b busy=%b depth=%h exp ready=01 busy=0 depth=0", req_ready, warp_busy, dvg_depth);
    end
    push_exp(NW_WIDTH'(2), req_split[0], '0);
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_rr();
    test_rr_hold();
    test_join_pending();
    test_overflow();
    test_underflow();
    test_proto();
    test_reset_midflight();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d outstanding exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
